// File: rtl/template_stream.sv
// template_stream: first-word fall-through stream buffer with occupancy count and
// almost-full flag. Storage is a circular array indexed by wrapping read/write pointers.
module template_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_almost_full
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam logic [CountW-1:0] DepthC = CountW'(DEPTH);
  localparam logic [CountW-1:0] AfC    = CountW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  push, pop;
  logic                  past_valid_q;

  // Status outputs derive only from registered occupancy; o_ready ignores i_ready so a
  // full buffer never accepts a word in the same cycle it drains one.
  always_comb begin
    o_ready       = (count_q < DepthC);
    o_valid       = (count_q != '0);
    o_data        = o_valid ? mem_q[rd_ptr_q] : '0;
    o_count       = count_q;
    o_almost_full = (count_q >= AfC);
  end

  // Transfer decode and next-state pointers/count; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    push     = i_valid && o_ready;
    pop      = o_valid && i_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale entries are hidden by the empty-forces-zero output.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Marks that the previous edge was a clean (non-reset) update, so $past is meaningful.
  always_ff @(posedge i_clk) begin
    past_valid_q <= i_reset_n;
  end

  a_count_step: assert property (@(posedge i_clk) past_valid_q |->
      int'(count_q) == int'($past(count_q)) + int'($past(push)) - int'($past(pop)));

  a_full_blocks: assert property (@(posedge i_clk) past_valid_q && (count_q == DepthC) |->
      !o_ready && !push);

  a_empty_quiet: assert property (@(posedge i_clk) past_valid_q && (count_q == '0) |->
      !o_valid && (o_data == '0) && !pop);

  a_count_bound: assert property (@(posedge i_clk) past_valid_q |-> count_q <= DepthC);

endmodule
